// File: rtl/vic_pkg.sv
// Shared types and helpers for the vectored interrupt controller.
// prio_first resolves a 16-bit request word to the lowest set index.
package vic_pkg;

  localparam int unsigned IDX_W = 4;

  typedef enum logic {
    IDLE,
    REPLY
  } vic_state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] index;
  } prio_t;

  // Scans from the top down so the last hit (lowest index) wins.
  function automatic prio_t prio_first(input logic [15:0] req);
    prio_t res;
    res.valid = 1'b0;
    res.index = '0;
    for (int i = 15; i >= 0; i--) begin
      if (req[i]) begin
        res.valid = 1'b1;
        res.index = IDX_W'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/vic_prio_enc.sv
// Fixed-priority encoder, bit 0 highest: yields valid, a one-hot grant
// and the binary index of the winning request.
module vic_prio_enc
  import vic_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] index
);

  logic [15:0] req_ext;
  prio_t       res;

  // Unused upper channels are tied off so the 16-bit helper sees no requests there.
  for (genvar gi = 0; gi < 16; gi++) begin : g_ext
    if (gi < N) begin : g_used
      assign req_ext[gi] = req[gi];
    end else begin : g_pad
      assign req_ext[gi] = 1'b0;
    end
  end

  assign res   = prio_first(req_ext);
  assign valid = res.valid;
  assign index = res.index;

  for (genvar gi = 0; gi < N; gi++) begin : g_grant
    assign grant[gi] = res.valid && (res.index == IDX_W'(gi));
  end

endmodule

// File: rtl/vic_multi.sv
// N-channel vectored interrupt controller: edge/level request latching,
// bus-writable mask, fixed priority and a two-state acknowledge handshake.
module vic_multi
  import vic_pkg::*;
#(
  parameter int             N         = 4,
  parameter int             VW        = 16,
  parameter logic [N-1:0]   EDGE      = {N{1'b1}},
  parameter logic [N-1:0]   MASK_INIT = {N{1'b0}},
  parameter logic [VW-1:0]  SPUR      = '0
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ce,
  input  logic [N-1:0]      ireq,
  input  logic [N*VW-1:0]   ivec,
  output logic [N-1:0]      iack,
  output logic              virq,
  input  logic              stb,
  output logic [VW-1:0]     dat,
  output logic              ack,
  input  logic              mask_we,
  input  logic [N-1:0]      mask_din,
  output logic [N-1:0]      mask_q
);

  vic_state_t       state_reg, state_next;
  logic [N-1:0]     hist_reg;
  logic [N-1:0]     pend_reg, pend_next;
  logic [N-1:0]     mask_q_reg;
  logic             virq_reg;
  logic             ack_reg, ack_next;
  logic [VW-1:0]    dat_reg, dat_next;
  logic [N-1:0]     iack_reg, iack_next;

  logic [N-1:0]     elig;
  logic             win_valid;
  logic [N-1:0]     win_grant;
  logic [IDX_W-1:0] win_idx;
  logic [VW-1:0]    win_vec;
  logic             svc;

  assign elig = pend_reg & ~mask_q_reg;

  vic_prio_enc #(
    .N (N)
  ) u_prio (
    .req   (elig),
    .valid (win_valid),
    .grant (win_grant),
    .index (win_idx)
  );

  always_comb begin
    win_vec = '0;
    for (int i = 0; i < N; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_vec = ivec[i*VW +: VW];
      end
    end
  end

  // A real (non-spurious) acknowledge accepted this clock.
  assign svc = ce && stb && (state_reg == IDLE) && win_valid;

  for (genvar gi = 0; gi < N; gi++) begin : g_pend
    if (EDGE[gi]) begin : g_edge
      // A fresh edge beats a service clear on the same clock.
      assign pend_next[gi] = (ce && ireq[gi] && !hist_reg[gi]) ? 1'b1 :
                             (svc && win_grant[gi])             ? 1'b0 :
                                                                  pend_reg[gi];
    end else begin : g_level
      assign pend_next[gi] = ce ? ireq[gi] : pend_reg[gi];
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hist_reg <= '0;
      pend_reg <= '0;
      virq_reg <= 1'b0;
    end else begin
      pend_reg <= pend_next;
      if (ce) begin
        hist_reg <= ireq;
        virq_reg <= |elig;
      end
    end
  end

  // Mask writes come straight from the bus and are not gated by ce.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      mask_q_reg <= MASK_INIT;
    end else if (mask_we) begin
      mask_q_reg <= mask_din;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      ack_reg   <= 1'b0;
      dat_reg   <= '0;
      iack_reg  <= '0;
    end else begin
      state_reg <= state_next;
      ack_reg   <= ack_next;
      dat_reg   <= dat_next;
      iack_reg  <= iack_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ack_next   = ack_reg;
    dat_next   = dat_reg;
    iack_next  = '0;
    case (state_reg)
      IDLE: begin
        if (ce && stb) begin
          state_next = REPLY;
          ack_next   = 1'b1;
          if (win_valid) begin
            dat_next  = win_vec;
            iack_next = win_grant;
          end else begin
            dat_next  = SPUR;
          end
        end
      end
      REPLY: begin
        if (ce && !stb) begin
          state_next = IDLE;
          ack_next   = 1'b0;
          dat_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        ack_next   = 1'b0;
        dat_next   = '0;
      end
    endcase
  end

  assign iack   = iack_reg;
  assign virq   = virq_reg;
  assign dat    = dat_reg;
  assign ack    = ack_reg;
  assign mask_q = mask_q_reg;

endmodule

// File: tb/tb_vic_multi.sv
// Self-checking bench for vic_multi: vector table, directed corner cases,
// then random traffic against a per-clock behavioural model.
module tb_vic_multi;

  localparam int             N            = 4;
  localparam int             VW           = 16;
  localparam logic [N-1:0]   TB_EDGE      = 4'b1110;
  localparam logic [N-1:0]   TB_MASK_INIT = 4'b0000;
  localparam logic [VW-1:0]  TB_SPUR      = 16'o000770;

  logic            clk_sys = 1'b0;
  logic            reset;
  logic            ce;
  logic [N-1:0]    ireq;
  logic [N*VW-1:0] ivec;
  logic [N-1:0]    iack;
  logic            virq;
  logic            stb;
  logic [VW-1:0]   dat;
  logic            ack;
  logic            mask_we;
  logic [N-1:0]    mask_din;
  logic [N-1:0]    mask_q;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [N-1:0]  m_pend, m_prev, m_mask, m_iack;
  logic          m_virq, m_busy, m_ack;
  logic [VW-1:0] m_dat;

  typedef struct {
    bit           ce;
    logic [N-1:0] rq;
    bit           stb;
    logic         e_virq;
    logic         e_ack;
    logic [N-1:0] e_iack;
    logic [VW-1:0] e_dat;
  } vec_t;

  vec_t tbl[14];

  vic_multi #(
    .N         (N),
    .VW        (VW),
    .EDGE      (TB_EDGE),
    .MASK_INIT (TB_MASK_INIT),
    .SPUR      (TB_SPUR)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ce       (ce),
    .ireq     (ireq),
    .ivec     (ivec),
    .iack     (iack),
    .virq     (virq),
    .stb      (stb),
    .dat      (dat),
    .ack      (ack),
    .mask_we  (mask_we),
    .mask_din (mask_din),
    .mask_q   (mask_q)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] vec_of(input int ch);
    return ivec[ch*VW +: VW];
  endfunction

  task automatic model_reset();
    m_pend = '0;
    m_prev = '0;
    m_mask = TB_MASK_INIT;
    m_virq = 1'b0;
    m_busy = 1'b0;
    m_ack  = 1'b0;
    m_dat  = '0;
    m_iack = '0;
  endtask

  // One clock of the reference behaviour, driven by the current bench inputs.
  task automatic model_update();
    logic [N-1:0] elig;
    logic [N-1:0] np;
    int           w;
    int           served;
    elig   = m_pend & ~m_mask;
    w      = -1;
    served = -1;
    for (int i = N - 1; i >= 0; i--) if (elig[i]) w = i;
    m_iack = '0;
    if (ce) begin
      if (!m_busy && stb) begin
        m_busy = 1'b1;
        m_ack  = 1'b1;
        if (w >= 0) begin
          m_dat  = vec_of(w);
          m_iack = N'(1 << w);
          served = w;
          $display("t=%0t ack channel %0d vector %06o", $time, w, m_dat);
        end else begin
          m_dat = TB_SPUR;
          $display("t=%0t ack spurious vector %06o", $time, m_dat);
        end
      end else if (m_busy && !stb) begin
        m_busy = 1'b0;
        m_ack  = 1'b0;
        m_dat  = '0;
      end
      m_virq = |elig;
      for (int i = 0; i < N; i++) begin
        if (!TB_EDGE[i])                  np[i] = ireq[i];
        else if (ireq[i] && !m_prev[i])   np[i] = 1'b1;
        else if (served == i)             np[i] = 1'b0;
        else                              np[i] = m_pend[i];
      end
      m_pend = np;
      m_prev = ireq;
    end
    if (mask_we) m_mask = mask_din;
  endtask

  task automatic step(input bit c, input logic [N-1:0] rq, input bit s,
                      input bit we, input logic [N-1:0] md);
    ce       = c;
    ireq     = rq;
    stb      = s;
    mask_we  = we;
    mask_din = md;
    @(posedge clk_sys);
    model_update();
    #1;
    chk("model_virq", virq, m_virq);
    chk("model_ack", ack, m_ack);
    chk("model_dat", dat, m_dat);
    chk("model_iack", iack, m_iack);
    chk("model_mask", mask_q, m_mask);
  endtask

  logic [N-1:0] r_rq;
  bit           r_stb;

  initial begin
    reset = 1'b1; ce = 1'b0; ireq = '0; stb = 1'b0; mask_we = 1'b0; mask_din = '0;
    ivec  = {16'o000114, 16'o000110, 16'o000104, 16'o000100};

    tbl[0]  = '{1, 4'b0100, 0, 0, 0, 4'b0000, 16'o0};
    tbl[1]  = '{1, 4'b0000, 0, 1, 0, 4'b0000, 16'o0};
    tbl[2]  = '{1, 4'b0000, 1, 1, 1, 4'b0100, 16'o000110};
    tbl[3]  = '{1, 4'b0000, 1, 0, 1, 4'b0000, 16'o000110};
    tbl[4]  = '{1, 4'b0000, 0, 0, 0, 4'b0000, 16'o0};
    tbl[5]  = '{0, 4'b1010, 0, 0, 0, 4'b0000, 16'o0};
    tbl[6]  = '{1, 4'b1010, 0, 0, 0, 4'b0000, 16'o0};
    tbl[7]  = '{1, 4'b1010, 0, 1, 0, 4'b0000, 16'o0};
    tbl[8]  = '{0, 4'b1010, 1, 1, 0, 4'b0000, 16'o0};
    tbl[9]  = '{1, 4'b1010, 1, 1, 1, 4'b0010, 16'o000104};
    tbl[10] = '{0, 4'b1010, 0, 1, 1, 4'b0000, 16'o000104};
    tbl[11] = '{1, 4'b1010, 0, 1, 0, 4'b0000, 16'o0};
    tbl[12] = '{1, 4'b1010, 1, 1, 1, 4'b1000, 16'o000114};
    tbl[13] = '{1, 4'b0000, 0, 0, 0, 4'b0000, 16'o0};

    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("rst_virq", virq, 1'b0);
    chk("rst_ack", ack, 1'b0);
    chk("rst_dat", dat, 16'h0);
    chk("rst_iack", iack, 4'h0);
    chk("rst_mask", mask_q, TB_MASK_INIT);
    reset = 1'b0;
    model_reset();

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].ce, tbl[i].rq, tbl[i].stb, 1'b0, 4'b0000);
      chk($sformatf("tbl_virq[%0d]", i), virq, tbl[i].e_virq);
      chk($sformatf("tbl_ack[%0d]", i), ack, tbl[i].e_ack);
      chk($sformatf("tbl_iack[%0d]", i), iack, tbl[i].e_iack);
      chk($sformatf("tbl_dat[%0d]", i), dat, tbl[i].e_dat);
    end

    // Masking a pending channel, then unmasking it
    step(1, 4'b0010, 0, 0, 4'b0000);
    step(1, 4'b0000, 0, 0, 4'b0000);  chk("mask_pre_virq", virq, 1'b1);
    step(1, 4'b0000, 0, 1, 4'b0010);  chk("mask_q_set", mask_q, 4'b0010);
    step(1, 4'b0000, 0, 0, 4'b0000);  chk("mask_virq_off", virq, 1'b0);
    step(1, 4'b0000, 0, 0, 4'b0000);  chk("mask_virq_stay", virq, 1'b0);
    step(1, 4'b0000, 0, 1, 4'b0000);  chk("unmask_q", mask_q, 4'b0000);
    step(1, 4'b0000, 0, 0, 4'b0000);  chk("unmask_virq", virq, 1'b1);
    step(1, 4'b0000, 1, 0, 4'b0000);  chk("unmask_dat", dat, 16'o000104);
                                      chk("unmask_iack", iack, 4'b0010);
    step(1, 4'b0000, 0, 0, 4'b0000);  chk("unmask_rel_ack", ack, 1'b0);

    // Spurious acknowledge
    step(1, 4'b0000, 1, 0, 4'b0000);  chk("spur_ack", ack, 1'b1);
                                      chk("spur_dat", dat, TB_SPUR);
                                      chk("spur_iack", iack, 4'b0000);
    step(1, 4'b0000, 0, 0, 4'b0000);  chk("spur_rel_dat", dat, 16'h0);

    // Level channel 0 held high
    step(1, 4'b0001, 0, 0, 4'b0000);
    step(1, 4'b0001, 0, 0, 4'b0000);  chk("lvl_virq", virq, 1'b1);
    step(1, 4'b0001, 1, 0, 4'b0000);  chk("lvl_dat1", dat, 16'o000100);
                                      chk("lvl_iack1", iack, 4'b0001);
    step(1, 4'b0001, 0, 0, 4'b0000);
    step(1, 4'b0001, 1, 0, 4'b0000);  chk("lvl_dat2", dat, 16'o000100);
                                      chk("lvl_iack2", iack, 4'b0001);
    step(1, 4'b0001, 0, 0, 4'b0000);  chk("lvl_virq_held", virq, 1'b1);
    step(1, 4'b0000, 0, 0, 4'b0000);  chk("lvl_drop1", virq, 1'b1);
    step(1, 4'b0000, 0, 0, 4'b0000);  chk("lvl_drop2", virq, 1'b0);

    // New edge on the same clock as its service: stays pending
    step(1, 4'b0100, 0, 0, 4'b0000);
    step(1, 4'b0000, 0, 0, 4'b0000);
    step(1, 4'b0100, 1, 0, 4'b0000);  chk("setwin_iack", iack, 4'b0100);
    step(1, 4'b0100, 0, 0, 4'b0000);  chk("setwin_virq", virq, 1'b1);
    step(1, 4'b0100, 1, 0, 4'b0000);  chk("setwin_dat2", dat, 16'o000110);
                                      chk("setwin_iack2", iack, 4'b0100);
    step(1, 4'b0000, 0, 0, 4'b0000);
    step(1, 4'b0000, 0, 0, 4'b0000);  chk("setwin_virq_off", virq, 1'b0);

    // Mask write on the acknowledge clock uses the old mask
    step(1, 4'b0110, 0, 0, 4'b0000);
    step(1, 4'b0000, 0, 0, 4'b0000);
    step(1, 4'b0000, 1, 1, 4'b0010);  chk("mwack_dat", dat, 16'o000104);
                                      chk("mwack_iack", iack, 4'b0010);
                                      chk("mwack_mask", mask_q, 4'b0010);
    step(1, 4'b0000, 0, 0, 4'b0000);
    step(1, 4'b0000, 1, 0, 4'b0000);  chk("mwack_dat2", dat, 16'o000110);
    step(1, 4'b0000, 0, 1, 4'b0000);

    // Async reset while replying
    step(1, 4'b0000, 0, 1, 4'b0100);
    step(1, 4'b1000, 0, 0, 4'b0000);
    step(1, 4'b1000, 0, 0, 4'b0000);  chk("rr_virq", virq, 1'b1);
    step(1, 4'b1000, 1, 0, 4'b0000);  chk("rr_dat", dat, 16'o000114);
    #2;
    reset = 1'b1; ireq = '0; stb = 1'b0; mask_we = 1'b0;
    #1;
    chk("rr_ack_now", ack, 1'b0);
    chk("rr_dat_now", dat, 16'h0);
    chk("rr_iack_now", iack, 4'h0);
    chk("rr_mask_now", mask_q, TB_MASK_INIT);
    chk("rr_virq_now", virq, 1'b0);
    model_reset();
    @(posedge clk_sys);
    @(negedge clk_sys);
    reset = 1'b0;
    step(1, 4'b0000, 0, 0, 4'b0000);
    step(1, 4'b1000, 0, 0, 4'b0000);
    step(1, 4'b1000, 0, 0, 4'b0000);  chk("post_virq", virq, 1'b1);
    step(1, 4'b1000, 1, 0, 4'b0000);  chk("post_dat", dat, 16'o000114);
                                      chk("post_iack", iack, 4'b1000);
    step(1, 4'b0000, 0, 0, 4'b0000);  chk("post_ack", ack, 1'b0);

    // Random traffic against the model
    for (int i = 0; i < N; i++) ivec[i*VW +: VW] = VW'($urandom);
    r_rq  = '0;
    r_stb = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0) r_rq = N'($urandom);
      if ($urandom_range(0, 2) == 0) r_stb = ~r_stb;
      step($urandom_range(0, 3) != 0, r_rq, r_stb,
           $urandom_range(0, 9) == 0, N'($urandom) & N'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
